// File: rtl/max_finder_pkg.sv
// Shared definitions for the maximum-search controller: FSM state encoding
// and default geometry of the operand memory.
package max_finder_pkg;

  localparam int DEFAULT_DEPTH  = 16;
  localparam int DEFAULT_ADDR_W = 4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_INIT = 3'd1;
  localparam logic [2:0] ST_READ = 3'd2;
  localparam logic [2:0] ST_CMP  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_INIT = ST_INIT,
    S_READ = ST_READ,
    S_CMP  = ST_CMP,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/max_finder_ctrl_addr_counter.sv
// Address counter for the operand memory walk. Counts up on inc until it
// reaches DEPTH-1 and then saturates, so it never wraps within a run.
module addr_counter
  import max_finder_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] count_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] count_d;

  // Next count: clear has priority, increment only below the last entry.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != LAST_ADDR)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == LAST_ADDR);

endmodule

// File: rtl/max_finder_ctrl.sv
// Sequencing controller for the maximum-search datapath. A rising edge of
// start clears the max register, then each memory entry gets one READ cycle
// (synchronous read) followed by one CMP cycle where the comparator result
// gt decides whether the max register loads. done stays up until the next run.
//
// Handshake: start is a level input; only a 0->1 transition seen at a clock
// edge launches a run, and it is honoured only in IDLE or DONE. There is no
// backpressure; done is a sticky status, not a pulse.
module max_finder_ctrl
  import max_finder_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              gt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              clr_max,
  output logic              ld_max,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_dbg_o
);

  state_e state_q;
  state_e state_d;
  logic   start_q;
  logic   go;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   cnt_last;
  logic [ADDR_W-1:0] cnt_val;

  // start_q resets high so a start held through reset is not seen as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b1;
    end else begin
      start_q <= start;
    end
  end

  assign go = start & ~start_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    state_d = state_q;
    clr_max = 1'b0;
    mem_rd  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (go) state_d = S_INIT;
      end
      S_INIT: begin
        clr_max = 1'b1;
        cnt_clr = 1'b1;
        busy    = 1'b1;
        state_d = S_READ;
      end
      S_READ: begin
        mem_rd  = 1'b1;
        busy    = 1'b1;
        state_d = S_CMP;
      end
      S_CMP: begin
        busy = 1'b1;
        if (cnt_last) begin
          state_d = S_DONE;
        end else begin
          cnt_inc = 1'b1;
          state_d = S_READ;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (go) state_d = S_INIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The only Mealy output: load when the fetched word beats the current max.
  assign ld_max = (state_q == S_CMP) & gt;

  addr_counter #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_addr_counter (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .count_o (cnt_val),
    .last_o  (cnt_last)
  );

  assign mem_addr    = cnt_val;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_max_finder_ctrl.sv
// Bench for max_finder_ctrl: a synchronous-read memory, comparator and max
// register around the controller, with expectations derived from the memory
// contents and the cycle timing of a run.
module tb_max_finder_ctrl;
  import max_finder_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT + datapath ----------------
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd, clr_max, ld_max, busy, done, gt;
  logic [2:0]        state_dbg;
  logic [7:0]        mem [DEPTH];
  logic [7:0]        rdata   = '0;
  logic [7:0]        max_reg = '0;

  always @(posedge clk) if (mem_rd) rdata <= mem[mem_addr];
  always @(posedge clk) begin
    if (clr_max)     max_reg <= '0;
    else if (ld_max) max_reg <= rdata;
  end
  assign gt = (rdata > max_reg);

  max_finder_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .gt          (gt),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .clr_max     (clr_max),
    .ld_max      (ld_max),
    .busy        (busy),
    .done        (done),
    .state_dbg_o (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".busy"},  32'(busy),      32'd0);
    check({tag, ".done"},  32'(done),      32'd0);
    check({tag, ".rd"},    32'(mem_rd),    32'd0);
    check({tag, ".clr"},   32'(clr_max),   32'd0);
    check({tag, ".ld"},    32'(ld_max),    32'd0);
    check({tag, ".state"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  // ---------------- memory fill helpers ----------------
  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic fill_zero();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'd0;
  endtask

  // One run: launch a start edge, then check every cycle c after edge E
  // (c = 1 is INIT) against the run timing. hold = cycles start stays high,
  // retog = cycle at which start is raised again while busy (0 = never),
  // abort_at = cycle at which rst is pulsed (0 = never).
  task automatic run_check(input string tag, input int hold, input int retog, input int abort_at);
    bit         new_max [DEPTH];
    logic [7:0] runmax;
    int         exp_ld_cnt;
    int         ld_cnt;
    logic       exp_ld, exp_rd;
    string      t;

    // Reference: an entry loads when strictly above the max of the entries before it.
    runmax = '0;
    exp_ld_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      new_max[i] = (mem[i] > runmax);
      if (new_max[i]) begin
        runmax = mem[i];
        exp_ld_cnt++;
      end
    end
    ld_cnt = 0;

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk);  // edge E
    for (int c = 1; c <= 2 * DEPTH + 4; c++) begin
      @(negedge clk);
      t = $sformatf("%s@%0d", tag, c);
      exp_rd = (c % 2 == 0) && (c <= 2 * DEPTH);
      exp_ld = (c % 2 == 1) && (c >= 3) && (c <= 2 * DEPTH + 1) && new_max[(c - 3) / 2];
      check({t, ".busy"}, 32'(busy),    32'(c <= 2 * DEPTH + 1));
      check({t, ".clr"},  32'(clr_max), 32'(c == 1));
      check({t, ".rd"},   32'(mem_rd),  32'(exp_rd));
      check({t, ".ld"},   32'(ld_max),  32'(exp_ld));
      check({t, ".done"}, 32'(done),    32'(c >= 2 * DEPTH + 2));
      if (exp_rd) check({t, ".addr"}, 32'(mem_addr), 32'((c - 2) / 2));
      if (c == 2 * DEPTH + 2) begin
        check({t, ".max"},    32'(max_reg), 32'(runmax));
        check({t, ".ld_cnt"}, 32'(ld_cnt),  32'(exp_ld_cnt));
      end
      if (c == abort_at) begin
        rst = 1'b1;
        #1 check_quiet({t, ".rst_async"});
        check({t, ".rst_addr"}, 32'(mem_addr), 32'd0);
        @(posedge clk); #1 rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check_quiet({t, ".rst_next"});
        return;
      end
      ld_cnt += int'(ld_max);
      start = (c < hold) || ((retog != 0) && (c == retog));
    end
    start = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int hold, retog;

    // Reset with start held high: outputs quiet, and no run after release.
    fill_zero();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_quiet($sformatf("start_thru_rst@%0d", i));
    end
    start = 1'b0;

    // Directed pattern {3,17,5,63,0,...}: loads at entries 0,1,3, max 0x3F.
    fill_zero();
    mem[0] = 8'd3; mem[1] = 8'd17; mem[2] = 8'd5; mem[3] = 8'h3F;
    run_check("pattern", 1, 0, 0);

    // All-zero memory: never loads, max stays 0.
    fill_zero();
    run_check("zeros", 1, 0, 0);

    // start held high for 10 cycles: exactly one run.
    fill_random();
    run_check("hold10", 10, 0, 0);

    // start re-raised while busy: ignored.
    fill_random();
    run_check("retoggle", 2, 12, 0);

    // rst during entry 7 read, then a clean rerun from address 0.
    fill_random();
    run_check("abort", 1, 0, 16);
    fill_random();
    run_check("rerun", 1, 0, 0);

    // Second run straight from DONE with ascending data: 15 loads, max 15.
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
    run_check("ascend", 1, 0, 0);

    // Randomised runs with random start hold and optional re-toggle.
    for (int r = 0; r < 4; r++) begin
      fill_random();
      hold  = $urandom_range(1, 12);
      retog = ($urandom_range(0, 1) == 1) ? hold + $urandom_range(2, 8) : 0;
      run_check($sformatf("rand%0d", r), hold, retog, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/max_finder_ctrl.md
# max_finder_ctrl

Sequencing controller for the maximum-search datapath. On a rising edge of `start` it clears the running-max register, then walks an address counter across the DEPTH-entry operand memory, issuing one read per entry. It asserts `ld_max` whenever the datapath comparator reports the fetched word greater than the current max. `done` is raised at the end of the run. It sits between the top-level `start`/`done` pins and the memory + comparator + max-register datapath that produces `maxnumber`.

## Interface
- `DEPTH`, 16: number of memory entries scanned per run (≥2).
- `ADDR_W`, 4: address width; must satisfy 2^ADDR_W ≥ DEPTH.

- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  run request; only the rising edge matters.
- `gt`  in  1  comparator result: memory data > current max register (unsigned).
- `mem_addr`  out  ADDR_W  memory read address (counter value).
- `mem_rd`  out  1  memory read strobe; data is valid on the following cycle.
- `clr_max`  out  1  synchronous clear of max register to 0.
- `ld_max`  out  1  load max register from memory data.
- `busy`  out  1  high from INIT through the last CMP.
- `done`  out  1  high while in DONE.

## Operation
- Edge detect: `start_q` samples `start` each clock. `start_q` resets to 1, so `start` held high through reset does not launch a run. `go = start & ~start_q`.
- States: IDLE, INIT, READ, CMP, DONE. On reset: IDLE, counter = 0, all outputs 0.
- IDLE: `go` → INIT; else stay.
- INIT: `clr_max` = 1, counter ← 0, `busy` = 1 → READ.
- READ: `mem_rd` = 1, `mem_addr` = counter, `busy` = 1 → CMP.
- CMP: `busy` = 1; `ld_max` = `gt`.
  - If counter == DEPTH-1 → DONE.
  - Else counter ← counter+1 → READ.
- DONE: `done` = 1.
  - `go` → INIT, starting a new run. `done` drops in INIT.
  - Else stay. `done` is sticky until the next run.
- `go` in INIT/READ/CMP is ignored. It is not queued.
- Counter never exceeds DEPTH-1 and does not wrap during a run. It holds its value in DONE/IDLE.
- All-zero memory: `ld_max` is never asserted. The max register stays 0, which is the correct result.
- Equal values (`gt` = 0) do not reload the register.
- `rst` asserted mid-run: immediate return to IDLE, outputs 0. The datapath max register is not guaranteed meaningful until the next completed run.

## Timing
- All outputs are Moore decodes of state, except `ld_max` = (state == CMP) & `gt`. `gt` must be combinational from registered memory data and the max register.
- Let edge E be the first posedge at which `start` = 1 and `start_q` = 0. Then:
  - INIT occupies the cycle after E.
  - Entry i is read in cycle 2+2i after E and compared in cycle 3+2i.
  - `done` rises 2+2·DEPTH posedges after E (34 for DEPTH = 16).
- Max register holds the final value in the same cycle `done` rises.
- Memory read latency is exactly 1 cycle (synchronous-read RAM/ROM).

## Structure
- Shared package `max_finder_pkg`:
  - state encoding localparams (IDLE = 0, INIT = 1, READ = 2, CMP = 3, DONE = 4; 3-bit),
  - default DEPTH / ADDR_W.
- Sub-module `addr_counter`: ADDR_W-bit up-counter with `clr`, `inc`, and `last` (= count == DEPTH-1) outputs. The FSM drives `clr` in INIT and `inc` in CMP when not `last`.
- FSM, `start` edge detector and output decode live in `max_finder_ctrl`.

## Test plan
- Reset, then a single `start` pulse with a memory model holding {3, 17, 5, 63, 0, …, 0}, DEPTH = 16:
  - `done` rises 34 cycles after the edge;
  - `ld_max` pulses exactly at entries 0, 1 and 3;
  - the datapath max reads 6'h3F.
- `start` held high for 10 cycles (100 ns) → exactly one run; no second INIT while `start` stays high.
- `start` toggled again while `busy` → ignored; address sequence 0..15 is uninterrupted; `done` timing is unchanged.
- All-zero memory → `ld_max` never asserted; `done` at +34; max = 0.
- `rst` pulsed during entry 7 → next cycle in IDLE with `busy`/`done`/`mem_rd` = 0. A fresh `start` edge reruns from address 0.
- After `done`, a second `start` edge with memory changed to ascending 0..15 → `done` drops in INIT, `ld_max` pulses 15 times (entries 1..15), final max = 15.
